// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding and one-hot result codes.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result bit order is {GT, EQ, LT}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/digit_cmp.sv
// Combinational DIGIT-bit unsigned comparator producing one-hot GT/EQ/LT.
module digit_cmp #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning DIGIT bits per cycle, MSB digit first,
// with valid/ready handshakes on both sides and per-transaction signed/unsigned mode.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DIGIT      = 2,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             outGT,
    output logic             outEQ,
    output logic             outLT,
    output logic             busy
);

    localparam int unsigned   NDIG = WIDTH / DIGIT;
    localparam int unsigned   CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] bias;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic [2:0]       held;
    logic [2:0]       dres;
    logic [2:0]       res_next;
    logic             dgt;
    logic             deq;
    logic             dlt;
    logic             last;
    logic             stop;

    digit_cmp #(
        .DIGIT(DIGIT)
    ) u_digit_cmp (
        .a  (sha[WIDTH-1 -: DIGIT]),
        .b  (shb[WIDTH-1 -: DIGIT]),
        .gt (dgt),
        .eq (deq),
        .lt (dlt)
    );

    always_comb begin
        // Flipping the sign bit of both operands maps two's complement order onto unsigned order.
        bias          = '0;
        bias[WIDTH-1] = in_signed;
        dres          = {dgt, deq, dlt};
        res_next      = decided ? held : dres;
        last          = (cnt == LAST);
        stop          = last || ((EARLY_EXIT != 0) && !deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            in_ready              <= 1'b1;
            busy                  <= 1'b0;
            out_valid             <= 1'b0;
            {outGT, outEQ, outLT} <= RES_NONE;
            cnt                   <= '0;
            decided               <= 1'b0;
            held                  <= RES_NONE;
            sha                   <= '0;
            shb                   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt     <= '0;
                    decided <= 1'b0;
                    if (in_valid) begin
                        sha      <= inA ^ bias;
                        shb      <= inB ^ bias;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        {outGT, outEQ, outLT} <= res_next;
                        out_valid             <= 1'b1;
                        state                 <= DONE;
                    end else begin
                        sha <= sha << DIGIT;
                        shb <= shb << DIGIT;
                        cnt <= cnt + 1'b1;
                        // Only the first differing digit may set the sticky result.
                        if (!decided && !deq) begin
                            decided <= 1'b1;
                            held    <= dres;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: six comparator configurations checked against a behavioural result/latency model.
module tb_serial_mag_comparator;

    typedef struct {
        int         inst;
        logic [2:0] res;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv16, iv4, or16, or4, s16, s4;
    logic [15:0] a16, b16;
    logic [3:0]  a4, b4;
    logic [5:0]  ir, ov, by;
    logic [2:0]  r [6];

    int   vec  = 0;
    int   misc = 0;
    exp_t sb[$];
    exp_t e0, e1;
    int   cw[6] = '{16, 16, 4, 4, 4, 4};
    int   cd[6] = '{2, 2, 1, 1, 2, 2};
    int   ce[6] = '{1, 0, 1, 0, 1, 0};

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(16), .DIGIT(2), .EARLY_EXIT(1)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir[0]), .inA(a16), .inB(b16),
        .in_signed(s16), .out_valid(ov[0]), .out_ready(or16), .outGT(r[0][2]), .outEQ(r[0][1]),
        .outLT(r[0][0]), .busy(by[0]));
    serial_mag_comparator #(.WIDTH(16), .DIGIT(2), .EARLY_EXIT(0)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir[1]), .inA(a16), .inB(b16),
        .in_signed(s16), .out_valid(ov[1]), .out_ready(or16), .outGT(r[1][2]), .outEQ(r[1][1]),
        .outLT(r[1][0]), .busy(by[1]));
    serial_mag_comparator #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(1)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir[2]), .inA(a4), .inB(b4),
        .in_signed(s4), .out_valid(ov[2]), .out_ready(or4), .outGT(r[2][2]), .outEQ(r[2][1]),
        .outLT(r[2][0]), .busy(by[2]));
    serial_mag_comparator #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(0)) u3 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir[3]), .inA(a4), .inB(b4),
        .in_signed(s4), .out_valid(ov[3]), .out_ready(or4), .outGT(r[3][2]), .outEQ(r[3][1]),
        .outLT(r[3][0]), .busy(by[3]));
    serial_mag_comparator #(.WIDTH(4), .DIGIT(2), .EARLY_EXIT(1)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir[4]), .inA(a4), .inB(b4),
        .in_signed(s4), .out_valid(ov[4]), .out_ready(or4), .outGT(r[4][2]), .outEQ(r[4][1]),
        .outLT(r[4][0]), .busy(by[4]));
    serial_mag_comparator #(.WIDTH(4), .DIGIT(2), .EARLY_EXIT(0)) u5 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir[5]), .inA(a4), .inB(b4),
        .in_signed(s4), .out_valid(ov[5]), .out_ready(or4), .outGT(r[5][2]), .outEQ(r[5][1]),
        .outLT(r[5][0]), .busy(by[5]));

    function automatic logic [2:0] ref_res(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic s);
        longint va = longint'(a);
        longint vb = longint'(b);
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        if (va > vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_lat(input int w, input int d, input int ee,
                                   input logic [15:0] a, input logic [15:0] b);
        int          nd = w / d;
        logic [15:0] x  = a ^ b;
        logic [15:0] m  = (16'd1 << d) - 16'd1;
        if (ee == 0) return nd;
        for (int k = 0; k < nd; k++) begin
            if (((x >> (w - d * (k + 1))) & m) != 16'd0) return k + 1;
        end
        return nd;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec++;
        assert (got === want)
        else begin
            misc++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic s);
        exp_t e;
        e.inst = i;
        e.res  = ref_res(cw[i], a, b, s);
        e.lat  = ref_lat(cw[i], cd[i], ce[i], a, b);
        sb.push_back(e);
    endtask

    // One transaction on group g (0: 16-bit pair, 1: 4-bit quad) with out_ready held high.
    task automatic run(input int g, input logic [15:0] a, input logic [15:0] b, input logic s);
        int         lo = (g == 0) ? 0 : 2;
        int         hi = (g == 0) ? 1 : 5;
        int         lat[6];
        logic [2:0] got[6];
        logic       seen[6];
        exp_t       e;
        for (int i = lo; i <= hi; i++) begin
            push_exp(i, a, b, s);
            seen[i] = 1'b0;
        end
        if (g == 0) begin
            a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; s4 = s; iv4 = 1'b1;
        end
        @(posedge clk); #1;
        iv16 = 1'b0; iv4 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            for (int i = lo; i <= hi; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = n;
                    got[i]  = r[i];
                end
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!seen[e.inst]) begin
                vec++; misc++;
                $error("FAIL timeout u%0d a=%h b=%h s=%0d: no out_valid", e.inst, a, b, s);
            end else begin
                chk($sformatf("res u%0d a=%h b=%h s=%0d", e.inst, a, b, s), 32'(got[e.inst]),
                    32'(e.res));
                chk($sformatf("lat u%0d a=%h b=%h s=%0d", e.inst, a, b, s), lat[e.inst], e.lat);
            end
            chk($sformatf("idle in_ready u%0d", e.inst), 32'(ir[e.inst]), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        iv16 = 1'b0; iv4 = 1'b0; or16 = 1'b1; or4 = 1'b1; s16 = 1'b0; s4 = 1'b0;
        a16 = '0; b16 = '0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("reset in_ready u%0d", i), 32'(ir[i]), 32'd1);
            chk($sformatf("reset out_valid u%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("reset result u%0d", i), 32'(r[i]), 32'd0);
            chk($sformatf("reset busy u%0d", i), 32'(by[i]), 32'd0);
        end
        reset = 1'b0;

        run(0, 16'h8000, 16'h7FFF, 1'b0);
        run(0, 16'h1234, 16'h1234, 1'b0);
        run(0, 16'hFFFF, 16'h0001, 1'b1);
        run(0, 16'hFFFF, 16'h0001, 1'b0);
        run(0, 16'h0005, 16'h0003, 1'b1);

        // Backpressure: results and in_ready must hold while out_ready is low.
        or16 = 1'b0;
        push_exp(0, 16'hC000, 16'h4000, 1'b1);
        push_exp(1, 16'hC000, 16'h4000, 1'b1);
        a16 = 16'hC000; b16 = 16'h4000; s16 = 1'b1; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        for (int n = 0; n < 12 && !(ov[0] && ov[1]); n++) begin
            @(posedge clk); #1;
        end
        e0 = sb.pop_front();
        e1 = sb.pop_front();
        for (int n = 0; n < 5; n++) begin
            a16 = 16'h0001; b16 = 16'hFFFE; s16 = 1'b0; iv16 = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp out_valid u0 c%0d", n), 32'(ov[0]), 32'd1);
            chk($sformatf("bp out_valid u1 c%0d", n), 32'(ov[1]), 32'd1);
            chk($sformatf("bp result u0 c%0d", n), 32'(r[0]), 32'(e0.res));
            chk($sformatf("bp result u1 c%0d", n), 32'(r[1]), 32'(e1.res));
            chk($sformatf("bp in_ready u0 c%0d", n), 32'(ir[0]), 32'd0);
            chk($sformatf("bp busy u1 c%0d", n), 32'(by[1]), 32'd1);
        end
        iv16 = 1'b0; or16 = 1'b1;
        @(posedge clk); #1;
        chk("post-hs out_valid u0", 32'(ov[0]), 32'd0);
        chk("post-hs in_ready u0", 32'(ir[0]), 32'd1);
        chk("post-hs busy u0", 32'(by[0]), 32'd0);
        chk("post-hs result hold u0", 32'(r[0]), 32'(e0.res));
        chk("post-hs result hold u1", 32'(r[1]), 32'(e1.res));

        // Reset during the third SCAN cycle of an equal-operand compare.
        a16 = 16'h1234; b16 = 16'h1234; s16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid-scan busy u0", 32'(by[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("abort in_ready u%0d", i), 32'(ir[i]), 32'd1);
            chk($sformatf("abort out_valid u%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("abort result u%0d", i), 32'(r[i]), 32'd0);
            chk($sformatf("abort busy u%0d", i), 32'(by[i]), 32'd0);
        end
        run(0, 16'h7FFF, 16'h8000, 1'b1);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run(1, 16'(a), 16'(b), s[0]);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
        $finish;
    end

endmodule
